dmem_port_arbiter: RTL and testbench

- Shares the single data-memory port (BRAM/DRAM split behind it) between two requesters: core MEM stage (requester 0) and host IO loader (requester 1).
- Registered request/grant sequencer with a valid/ready handshake toward memory and a one-cycle done pulse toward the granted requester.
- Replaces the combinational core_start/core_end steering of the memory port.

---
 rtl/dmem_port_arbiter.sv | 90 +++++++++
 tb/tb_dmem_port_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: registered IDLE/BUSY/DONE sequencer sharing one data-memory port between core (0) and IO loader (1); define RR_ARB_EN for round-robin ties, else core wins ties
// Ports: clk/rstn (sync, active-low); core_mode blocks new IO grants;
//   req/we/addr/wdata 0,1 requester side with one-cycle done0/done1 and shared rdata;
//   busy, gnt_id status; mem_valid/mem_rw/mem_addr/mem_wdata to memory, mem_rdata/mem_ready back.
module dmem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              core_mode,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              done0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              gnt_id,
  output logic              mem_valid,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic   any_req;
  logic   pick1;
`ifdef RR_ARB_EN
  // granted_once keeps gnt_id's reset value from handing the very first tie to IO
  logic   granted_once;
  always_comb pick1 = req1 & ~core_mode & (~req0 | (granted_once & ~gnt_id));
`else
  always_comb pick1 = req1 & ~core_mode & ~req0;
`endif
  always_comb any_req = req0 | (req1 & ~core_mode);
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      mem_valid <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      busy      <= 1'b0;
      gnt_id    <= 1'b0;
      mem_rw    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
`ifdef RR_ARB_EN
      granted_once <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (any_req) begin
          state     <= BUSY;
          mem_valid <= 1'b1;
          busy      <= 1'b1;
          gnt_id    <= pick1;
          mem_rw    <= pick1 ? we1 : we0;
          mem_addr  <= pick1 ? addr1 : addr0;
          mem_wdata <= pick1 ? wdata1 : wdata0;
`ifdef RR_ARB_EN
          granted_once <= 1'b1;
`endif
        end
        BUSY: if (mem_ready) begin
          state     <= DONE;
          mem_valid <= 1'b0;
          done0     <= ~gnt_id;
          done1     <= gnt_id;
          if (!mem_rw) rdata <= mem_rdata;
        end
        DONE: begin
          state <= IDLE;
          done0 <= 1'b0;
          done1 <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed plus randomized checks of dmem_port_arbiter against a transaction-level model
module tb_dmem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef RR_ARB_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0, rstn = 1'b0, core_mode = 1'b0;
  logic req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0, mem_ready = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0, mem_rdata = '0;
  logic done0, done1, busy, gnt_id, mem_valid, mem_rw;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, rdata;
  int n_tests = 0, n_fail = 0;
  // model: phase 0 = free, 1 = transaction outstanding, 2 = completion cycle
  int ph = 0;
  logic own = 1'b0, gv = 1'b0, t_rw = 1'b0;
  logic [AW-1:0] t_addr = '0;
  logic [DW-1:0] t_wd = '0, m_rd = '0;
  int done_seq[$];
  int vcnt;
  logic [DW-1:0] saved;
  always #5 clk = ~clk;
  dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rstn(rstn), .core_mode(core_mode),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .done0(done0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .done1(done1),
    .rdata(rdata), .busy(busy), .gnt_id(gnt_id),
    .mem_valid(mem_valid), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model_step();
    logic c0, c1, w;
    c0 = req0;
    c1 = req1 && !core_mode;
    if (!rstn) begin
      ph = 0; own = 0; gv = 0; t_rw = 0; t_addr = '0; t_wd = '0; m_rd = '0;
    end else if (ph == 0) begin
      if (c0 || c1) begin
        w = (c0 && c1) ? (RR && gv && !own) : c1;
        own = w; gv = 1; ph = 1;
        t_rw = w ? we1 : we0;
        t_addr = w ? addr1 : addr0;
        t_wd = w ? wdata1 : wdata0;
      end
    end else if (ph == 1) begin
      if (mem_ready) begin
        if (!t_rw) m_rd = mem_rdata;
        ph = 2;
      end
    end else ph = 0;
  endtask
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("mem_valid", mem_valid, ph == 1);
    chk("busy", busy, ph != 0);
    chk("done0", done0, ph == 2 && !own);
    chk("done1", done1, ph == 2 && own);
    chk("gnt_id", gnt_id, own);
    chk("mem_rw", mem_rw, t_rw);
    chk("mem_addr", mem_addr, t_addr);
    chk("mem_wdata", mem_wdata, t_wd);
    chk("rdata", rdata, m_rd);
    if (done0) done_seq.push_back(0);
    if (done1) done_seq.push_back(1);
  endtask
  initial begin
    rstn = 0;
    tick(); tick();
    chk("rst_valid", mem_valid, 0);
    chk("rst_rdata", rdata, 0);
    rstn = 1;
    // core read answered on the first mem_valid cycle
    req0 = 1; we0 = 0; addr0 = 32'h100; mem_ready = 1; mem_rdata = 32'hDEADBEEF;
    tick();
    chk("rd_valid1", mem_valid, 1);
    tick();
    chk("rd_done0", done0, 1);
    chk("rd_done1", done1, 0);
    chk("rd_data", rdata, 32'hDEADBEEF);
    chk("rd_valid_off", mem_valid, 0);
    req0 = 0; mem_ready = 0;
    tick();
    // IO write with 15-cycle memory latency; IO inputs wander while busy
    req1 = 1; we1 = 1; addr1 = 32'h8000; wdata1 = 32'h12345678;
    tick();
    vcnt = mem_valid;
    for (int i = 0; i < 14; i++) begin
      addr1 = $urandom; wdata1 = $urandom; we1 = $urandom_range(0, 1);
      tick();
      vcnt += mem_valid;
    end
    mem_ready = 1;
    tick();
    chk("wr_valid_cycles", vcnt, 15);
    chk("wr_done1", done1, 1);
    chk("wr_addr", mem_addr, 32'h8000);
    chk("wr_wdata", mem_wdata, 32'h12345678);
    chk("wr_rdata_kept", rdata, 32'hDEADBEEF);
    req1 = 0; mem_ready = 0;
    tick();
    // IO held off by core_mode; stray mem_ready is ignored meanwhile
    core_mode = 1; req1 = 1; we1 = 0; addr1 = 32'h44; mem_ready = 1; mem_rdata = $urandom;
    vcnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      vcnt += busy;
    end
    chk("blocked_busy", vcnt, 0);
    core_mode = 0;
    tick();
    chk("io_grant", gnt_id, 1);
    tick();
    chk("io_done1", done1, 1);
    req1 = 0; mem_ready = 0;
    tick();
    // both requesters held, immediate memory
    done_seq.delete();
    req0 = 1; req1 = 1; we0 = 0; we1 = 0; mem_ready = 1;
    for (int i = 0; i < 12; i++) tick();
    req0 = 0; req1 = 0;
    tick();
    chk("tie_count", done_seq.size(), 4);
    for (int i = 0; i < done_seq.size(); i++) chk("tie_order", done_seq[i], RR ? i % 2 : 0);
    mem_ready = 0;
    tick();
    // reset while a transaction is outstanding
    req0 = 1; we0 = 0; addr0 = 32'h300;
    tick(); tick();
    rstn = 0; done_seq.delete();
    tick();
    chk("mid_rst_valid", mem_valid, 0);
    chk("mid_rst_busy", busy, 0);
    rstn = 1; we0 = 1; addr0 = 32'h200; wdata0 = 32'hA5A5;
    tick();
    mem_ready = 1;
    tick();
    chk("after_rst_done0", done0, 1);
    chk("after_rst_dones", done_seq.size(), 1);
    req0 = 0; mem_ready = 0;
    tick();
    // stray mem_ready while idle
    saved = rdata; mem_ready = 1; mem_rdata = 32'hCAFEF00D;
    tick(); tick(); tick();
    chk("idle_ready_rdata", rdata, saved);
    chk("idle_ready_busy", busy, 0);
    mem_ready = 0;
    // randomized traffic; requests stay stable until their done
    for (int i = 0; i < 2500; i++) begin
      rstn = ($urandom_range(0, 299) != 0);
      core_mode = ($urandom_range(0, 3) == 0);
      mem_ready = ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;
      if (!req0 || (ph == 2 && !own)) begin
        req0 = ($urandom_range(0, 2) == 0);
        we0 = $urandom_range(0, 1); addr0 = $urandom; wdata0 = $urandom;
      end
      if (!req1 || (ph == 2 && own)) begin
        req1 = ($urandom_range(0, 1) == 0);
        we1 = $urandom_range(0, 1); addr1 = $urandom; wdata1 = $urandom;
      end
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
